// File: rtl/morse_buzzer_sequencer.sv
// Morse buzzer sequencer: three push-button timing levels plus a per-symbol
// tone/gap player behind a valid/ready handshake.
module morse_buzzer_sequencer #(
  parameter int TICK_DIV  = 10_000_000,
  parameter int TONE_HALF = 0,
  parameter int TICK_W    = 8,
  parameter int LONG1     = 10,
  parameter int LONG2     = 16,
  parameter int LONG3     = 20,
  parameter int SHORT1    = 2,
  parameter int SHORT2    = 6,
  parameter int SHORT3    = 8,
  parameter int SPACE0    = 6,
  parameter int SPACE1    = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_long,
  input  logic       btn_short,
  input  logic       btn_space,
  input  logic       sym_valid,
  input  logic       sym_dash,
  output logic       sym_ready,
  input  logic       abort,
  output logic       buzzer,
  output logic       busy,
  output logic       done,
  output logic [1:0] lvl_long,
  output logic [1:0] lvl_short,
  output logic       lvl_space
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HALF_MAX  = HW'((TONE_HALF > 0) ? TONE_HALF - 1 : 0);

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [HW-1:0]     half_q, half_d;
  logic [TICK_W-1:0] tone_q, tone_d;
  logic [TICK_W-1:0] gap_q, gap_d;
  logic              buzz_q, buzz_d;
  logic              done_q, done_d;
  logic [1:0]        lvl_long_q, lvl_long_d;
  logic [1:0]        lvl_short_q, lvl_short_d;
  logic              lvl_space_q, lvl_space_d;
  logic [2:0]        btn_prev_q, btn_prev_d;
  logic [2:0]        btn_now, btn_rise;

  function automatic logic [1:0] step3(input logic [1:0] l);
    return (l == 2'd3) ? 2'd1 : l + 2'd1;
  endfunction

  function automatic logic [TICK_W-1:0] long_ticks(input logic [1:0] l);
    case (l)
      2'd2:    return TICK_W'(LONG2);
      2'd3:    return TICK_W'(LONG3);
      default: return TICK_W'(LONG1);
    endcase
  endfunction

  function automatic logic [TICK_W-1:0] short_ticks(input logic [1:0] l);
    case (l)
      2'd2:    return TICK_W'(SHORT2);
      2'd3:    return TICK_W'(SHORT3);
      default: return TICK_W'(SHORT1);
    endcase
  endfunction

  assign btn_now  = {btn_long, btn_short, btn_space};
  assign btn_rise = btn_now & ~btn_prev_q;

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    half_d      = half_q;
    tone_d      = tone_q;
    gap_d       = gap_q;
    buzz_d      = buzz_q;
    done_d      = 1'b0;
    btn_prev_d  = btn_now;
    lvl_long_d  = btn_rise[2] ? step3(lvl_long_q)  : lvl_long_q;
    lvl_short_d = btn_rise[1] ? step3(lvl_short_q) : lvl_short_q;
    lvl_space_d = btn_rise[0] ? ~lvl_space_q       : lvl_space_q;

    case (state_q)
      IDLE: begin
        buzz_d = 1'b0;
        if (!abort && sym_valid) begin
          tone_d  = sym_dash ? long_ticks(lvl_long_q) : short_ticks(lvl_short_q);
          gap_d   = lvl_space_q ? TICK_W'(SPACE1) : TICK_W'(SPACE0);
          presc_d = '0;
          half_d  = '0;
          buzz_d  = 1'b1;
          state_d = TONE;
        end
      end
      TONE: begin
        if (abort) begin
          state_d = IDLE;
          buzz_d  = 1'b0;
          presc_d = '0;
          half_d  = '0;
          tone_d  = '0;
          gap_d   = '0;
        end else begin
          if (TONE_HALF > 0) begin
            if (half_q == HALF_MAX) begin
              half_d = '0;
              buzz_d = ~buzz_q;
            end else begin
              half_d = half_q + HW'(1);
            end
          end
          // Tone expiry overrides any toggle so the gap always starts silent.
          if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            if (tone_q == TICK_W'(1)) begin
              state_d = GAP;
              tone_d  = '0;
              half_d  = '0;
              buzz_d  = 1'b0;
            end else begin
              tone_d = tone_q - TICK_W'(1);
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      GAP: begin
        buzz_d = 1'b0;
        if (abort) begin
          state_d = IDLE;
          presc_d = '0;
          half_d  = '0;
          tone_d  = '0;
          gap_d   = '0;
        end else if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          if (gap_q == TICK_W'(1)) begin
            state_d = IDLE;
            gap_d   = '0;
            done_d  = 1'b1;
          end else begin
            gap_d = gap_q - TICK_W'(1);
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      half_q      <= '0;
      tone_q      <= '0;
      gap_q       <= '0;
      buzz_q      <= 1'b0;
      done_q      <= 1'b0;
      lvl_long_q  <= 2'd1;
      lvl_short_q <= 2'd1;
      lvl_space_q <= 1'b0;
      btn_prev_q  <= '1;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      half_q      <= half_d;
      tone_q      <= tone_d;
      gap_q       <= gap_d;
      buzz_q      <= buzz_d;
      done_q      <= done_d;
      lvl_long_q  <= lvl_long_d;
      lvl_short_q <= lvl_short_d;
      lvl_space_q <= lvl_space_d;
      btn_prev_q  <= btn_prev_d;
    end
  end

  assign sym_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign buzzer    = buzz_q;
  assign done      = done_q;
  assign lvl_long  = lvl_long_q;
  assign lvl_short = lvl_short_q;
  assign lvl_space = lvl_space_q;

endmodule

// File: tb/tb_morse_buzzer_sequencer.sv
// Directed bench: a steady-tone and a toggling-tone instance share all inputs.
module tb_morse_buzzer_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_long, btn_short, btn_space;
  logic       sym_valid, sym_dash, abort;
  logic       sym_ready, buzzer, busy, done;
  logic [1:0] lvl_long, lvl_short;
  logic       lvl_space;
  logic       sym_ready2, buzzer2, busy2, done2;
  logic [1:0] lvl_long2, lvl_short2;
  logic       lvl_space2;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned hi, dn;
  logic        b80, b81;
  logic [7:0]  pat;

  always #5 clk = ~clk;

  morse_buzzer_sequencer #(.TICK_DIV(4), .TONE_HALF(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .btn_long(btn_long), .btn_short(btn_short),
    .btn_space(btn_space), .sym_valid(sym_valid), .sym_dash(sym_dash),
    .sym_ready(sym_ready), .abort(abort), .buzzer(buzzer), .busy(busy),
    .done(done), .lvl_long(lvl_long), .lvl_short(lvl_short), .lvl_space(lvl_space)
  );

  morse_buzzer_sequencer #(.TICK_DIV(4), .TONE_HALF(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .btn_long(btn_long), .btn_short(btn_short),
    .btn_space(btn_space), .sym_valid(sym_valid), .sym_dash(sym_dash),
    .sym_ready(sym_ready2), .abort(abort), .buzzer(buzzer2), .busy(busy2),
    .done(done2), .lvl_long(lvl_long2), .lvl_short(lvl_short2), .lvl_space(lvl_space2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_long();
    btn_long = 1'b1; tick(); btn_long = 1'b0; tick();
  endtask

  task automatic pulse_short();
    btn_short = 1'b1; tick(); btn_short = 1'b0; tick();
  endtask

  task automatic pulse_space();
    btn_space = 1'b1; tick(); btn_space = 1'b0; tick();
  endtask

  task automatic send(input logic dash);
    sym_valid = 1'b1; sym_dash = dash; tick(); sym_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; btn_long = 1'b0; btn_short = 1'b0; btn_space = 1'b1;
    sym_valid = 1'b0; sym_dash = 1'b0; abort = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    chk("rst_lvl_long", lvl_long, 1);
    chk("rst_lvl_short", lvl_short, 1);
    chk("rst_lvl_space", lvl_space, 0);
    chk("rst_buzzer", buzzer, 0);
    chk("rst_ready", sym_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // Button held through reset release must not toggle
    tick(); tick();
    chk("space_held_rst", lvl_space, 0);
    btn_space = 1'b0; tick();

    pulse_long();  chk("long_step2", lvl_long, 2);
    pulse_long();  chk("long_step3", lvl_long, 3);
    pulse_long();  chk("long_wrap1", lvl_long, 1);
    btn_short = 1'b1; repeat (10) tick(); btn_short = 1'b0; tick();
    chk("short_hold", lvl_short, 2);
    pulse_short(); pulse_short();
    chk("short_wrap1", lvl_short, 1);

    // Dot at default levels: 8 high, 24 low, done at k+33, held valid re-accepts
    sym_valid = 1'b1; sym_dash = 1'b0; tick();
    for (int i = 1; i <= 32; i++) begin
      chk($sformatf("dot_buz_%0d", i), buzzer, (i <= 8) ? 1 : 0);
      chk($sformatf("dot_busy_%0d", i), busy, 1);
      chk($sformatf("dot_done_%0d", i), done, 0);
      tick();
    end
    chk("dot_done", done, 1);
    chk("dot_ready", sym_ready, 1);
    chk("dot_idle", busy, 0);
    tick();
    chk("b2b_buz", buzzer, 1);
    chk("b2b_ready", sym_ready, 0);
    chk("b2b_done_clr", done, 0);
    sym_valid = 1'b0;
    repeat (32) tick();
    chk("b2b_done", done, 1);

    // Dash with long level 3 and space level 1: 80 high, 40 gap
    pulse_long(); pulse_long(); pulse_space();
    chk("dash_lvl_long", lvl_long, 3);
    chk("dash_lvl_space", lvl_space, 1);
    send(1'b1);
    hi = 0; dn = 0; b80 = 1'b0; b81 = 1'b1;
    for (int i = 1; i <= 120; i++) begin
      hi += buzzer; dn += done;
      if (i == 80) b80 = buzzer;
      if (i == 81) b81 = buzzer;
      tick();
    end
    chk("dash_hi", hi, 80);
    chk("dash_last_hi", b80, 1);
    chk("dash_gap_lo", b81, 0);
    chk("dash_early_done", dn, 0);
    chk("dash_done", done, 1);
    tick();
    chk("dash_done_pulse", done, 0);

    // Short level stepped mid-tone: current dot keeps 8, next dot uses 24
    send(1'b0);
    hi = 0;
    for (int i = 1; i <= 48; i++) begin
      if (i == 3) btn_short = 1'b1;
      if (i == 4) btn_short = 1'b0;
      hi += buzzer;
      tick();
    end
    chk("mid_hi", hi, 8);
    chk("mid_done", done, 1);
    chk("mid_lvl_short", lvl_short, 2);
    send(1'b0);
    hi = 0;
    for (int i = 1; i <= 64; i++) begin
      hi += buzzer;
      tick();
    end
    chk("new_hi", hi, 24);
    chk("new_done", done, 1);

    // Abort beats sym_valid in IDLE
    sym_valid = 1'b1; abort = 1'b1; tick();
    chk("abort_idle_ready", sym_ready, 1);
    chk("abort_idle_busy", busy, 0);
    abort = 1'b0; tick(); sym_valid = 1'b0;
    chk("abort_acc_buz", buzzer, 1);
    repeat (4) tick();
    chk("abort_pre_buz", buzzer, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_buz", buzzer, 0);
    chk("abort_ready", sym_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    dn = 0;
    for (int i = 0; i < 50; i++) begin
      dn += done;
      tick();
    end
    chk("abort_no_done", dn, 0);

    // Toggling tone on second instance, then async reset mid-gap
    pulse_short(); pulse_short();
    chk("t6_lvl_short", lvl_short, 1);
    pat = 8'b0011_0011;
    send(1'b0);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("half_buz_%0d", i), buzzer2, pat[i-1]);
      chk($sformatf("steady_buz_%0d", i), buzzer, 1);
      tick();
    end
    chk("half_gap_buz", buzzer2, 0);
    repeat (10) tick();
    chk("gap_busy", busy2, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_buz", buzzer, 0);
    chk("arst_buz2", buzzer2, 0);
    chk("arst_busy", busy, 0);
    chk("arst_busy2", busy2, 0);
    chk("arst_ready", sym_ready2, 1);
    chk("arst_lvl_long", lvl_long, 1);
    chk("arst_lvl_short", lvl_short, 1);
    chk("arst_lvl_space", lvl_space, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
